// File: rtl/rgb_pwm_gen_pkg.sv
// Shared definitions for the RGB PWM generator: duty width, channel indices,
// the duty-set type and the handshake FSM state encoding.
package rgb_pwm_gen_pkg;

  localparam int DUTY_W = 8;
  localparam int NUM_CH = 3;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // One duty per channel; bit layout matches duty_data ([7:0] red ... [23:16] blue).
  typedef logic [NUM_CH-1:0][DUTY_W-1:0] duty_set_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: unsigned compare of the frame step against the channel duty,
// registered so every channel shares the same one-clock latency.
module pwm_channel
  import rgb_pwm_gen_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  // Compare at the wider of the two widths so RES > 256 still works.
  localparam int CMP_W = (STEP_W > DUTY_W) ? STEP_W : DUTY_W;

  logic [CMP_W-1:0] step_ext;
  logic [CMP_W-1:0] duty_ext;

  assign step_ext = CMP_W'(step);
  assign duty_ext = CMP_W'(duty);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en && (step_ext < duty_ext);
    end
  end

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB PWM generator: prescaler, frame step counter, duty handshake FSM and
// three pwm_channel instances; new duties take effect only at frame boundaries.
module rgb_pwm_gen
  import rgb_pwm_gen_pkg::*;
#(
  parameter int PRESCALE = 47,
  parameter int RES      = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH*DUTY_W-1:0] duty_data,
  input  logic                     duty_valid,
  output logic                     duty_ready,
  output logic                     pwm_r,
  output logic                     pwm_g,
  output logic                     pwm_b,
  output logic                     frame_tick
);

  localparam int                STEP_W    = (RES > 1) ? $clog2(RES) : 1;
  localparam logic [15:0]       PRESC_MAX = 16'(PRESCALE);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(RES - 1);

  logic [15:0]       presc;
  logic [STEP_W-1:0] step;
  logic              step_tick;
  logic              wrap;

  state_t    state;
  state_t    state_nxt;
  logic      capture;
  logic      apply;
  duty_set_t pend_duty;
  duty_set_t act_duty;

  logic [NUM_CH-1:0] pwm_q;

  assign step_tick = en && (presc == PRESC_MAX);
  assign wrap      = step_tick && (step == STEP_MAX);

  // Disabling the generator parks both counters at 0 so re-enabling starts a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      step       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (!en || step_tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 16'd1;
      end
      if (!en || wrap) begin
        step <= '0;
      end else if (step_tick) begin
        step <= step + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    duty_ready = 1'b0;
    capture    = 1'b0;
    apply      = 1'b0;
    case (state)
      ST_IDLE: begin
        duty_ready = 1'b1;
        if (duty_valid) begin
          capture   = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!en || wrap) begin
          apply     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the duty registers are reset (not left as uninitialised storage) so
  // the outputs are defined low before the first transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_duty <= '0;
      act_duty  <= '0;
    end else begin
      if (capture) begin
        pend_duty <= duty_data;
      end
      if (apply) begin
        act_duty <= pend_duty;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel #(
      .STEP_W(STEP_W)
    ) u_pwm (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .step (step),
      .duty (act_duty[ch]),
      .pwm  (pwm_q[ch])
    );
  end

  assign pwm_r = pwm_q[CH_R];
  assign pwm_g = pwm_q[CH_G];
  assign pwm_b = pwm_q[CH_B];

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen: two instances (PRESCALE 0 and 3) share
// stimulus; a frame-arithmetic reference model predicts every output each cycle.
module tb_rgb_pwm_gen;

  localparam int RES = 255;
  localparam int P_A = 0;
  localparam int P_B = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        duty_valid = 1'b0;
  logic [23:0] duty_data = '0;

  logic rdy_a, ft_a, r_a, g_a, b_a;
  logic rdy_b, ft_b, r_b, g_b, b_b;

  always #5 clk = ~clk;

  rgb_pwm_gen #(.PRESCALE(P_A), .RES(RES)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_data(duty_data), .duty_valid(duty_valid),
    .duty_ready(rdy_a), .pwm_r(r_a), .pwm_g(g_a), .pwm_b(b_a), .frame_tick(ft_a)
  );

  rgb_pwm_gen #(.PRESCALE(P_B), .RES(RES)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_data(duty_data), .duty_valid(duty_valid),
    .duty_ready(rdy_b), .pwm_r(r_b), .pwm_g(g_b), .pwm_b(b_b), .frame_tick(ft_b)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Reference model: position in the frame is enabled-cycle count divided by
  // the prescale period; a captured duty waits in a one-deep slot for a boundary.
  int unsigned m_cnt  [2];
  logic [23:0] m_act  [2];
  logic [23:0] m_pend [2];
  bit          m_pv   [2];
  logic [4:0]  m_exp  [2];

  function automatic int unsigned period_of(input int i);
    return (i == 0) ? P_A + 1 : P_B + 1;
  endfunction

  function automatic logic [4:0] got(input int i);
    return (i == 0) ? {rdy_a, ft_a, r_a, g_a, b_a} : {rdy_b, ft_b, r_b, g_b, b_b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_act[i]  = '0;
      m_pend[i] = '0;
      m_pv[i]   = 1'b0;
      m_exp[i]  = 5'b10000;
    end
  endtask

  task automatic model_edge(input int i);
    int unsigned p;
    int unsigned ph;
    int unsigned st;
    bit          wrap;
    logic [2:0]  pw;
    p    = period_of(i);
    ph   = m_cnt[i] % p;
    st   = (m_cnt[i] / p) % RES;
    wrap = en && (ph == p - 1) && (st == RES - 1);
    for (int ch = 0; ch < 3; ch++) begin
      pw[ch] = en && (st < int'(m_act[i][ch*8 +: 8]));
    end
    if (!m_pv[i]) begin
      if (duty_valid) begin
        m_pend[i] = duty_data;
        m_pv[i]   = 1'b1;
      end
    end else if (!en || wrap) begin
      m_act[i] = m_pend[i];
      m_pv[i]  = 1'b0;
    end
    m_cnt[i] = en ? m_cnt[i] + 1 : 0;
    m_exp[i] = {!m_pv[i], wrap, pw[0], pw[1], pw[2]};
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check("cyc_a", got(0), m_exp[0]);
    check("cyc_b", got(1), m_exp[1]);
  endtask

  task automatic count_window(input int i, input int n, output int hr, output int hg,
                              output int hb, output int nft);
    logic [4:0] o;
    hr = 0; hg = 0; hb = 0; nft = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      o = got(i);
      hr += o[2]; hg += o[1]; hb += o[0]; nft += o[3];
    end
  endtask

  task automatic wait_tick(input int i, input int max, input string name);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!got(i)[3] && k < max);
    check(name, got(i)[3], 1);
  endtask

  task automatic wait_ready_both(input int max, input string name);
    int k;
    k = 0;
    while (!(rdy_a && rdy_b) && k < max) begin
      cycle();
      k++;
    end
    check(name, rdy_a && rdy_b, 1);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_a", got(0), 5'b10000);
    check("rst_async_b", got(1), 5'b10000);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rnd_duty();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'($urandom_range(250, 254));
      default: return 8'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [23:0] data;
    int          a_r, a_g, a_b;
    int          b_r, b_g, b_b;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   hr, hg, hb, nft, nticks, hi, first_ft;

    // High-clock counts per frame: duty k -> k steps, duty >= RES -> whole frame;
    // instance B stretches every step to 4 clocks.
    tbl[0] = '{24'h00FF40,  64, 255,   0,  256, 1020,    0};
    tbl[1] = '{24'h010203,   3,   2,   1,   12,    8,    4};
    tbl[2] = '{24'hFE7F00,   0, 127, 254,    0,  508, 1016};
    tbl[3] = '{24'h8000FF, 255,   0, 128, 1020,    0,  512};
    tbl[4] = '{24'h000002,   2,   0,   0,    8,    0,    0};

    model_reset();
    #3;
    check("rst_a", got(0), 5'b10000);
    check("rst_b", got(1), 5'b10000);
    cycle();
    cycle();
    rst_n = 1'b1;
    en    = 1'b1;

    // Three idle frames: outputs low, frame_tick every RES clocks.
    nticks = 0;
    hi     = 0;
    for (int k = 0; k < 3 * RES; k++) begin
      cycle();
      if (ft_a) begin
        check($sformatf("idle_tick_pos%0d", nticks), k, 254 + RES * nticks);
        nticks++;
      end
      hi += int'(r_a | g_a | b_a);
    end
    check("idle_ticks", nticks, 3);
    check("idle_pwm_high", hi, 0);

    for (int v = 0; v < 5; v++) begin
      duty_data  = tbl[v].data;
      duty_valid = 1'b1;
      cycle();
      duty_valid = 1'b0;
      check($sformatf("v%0d_ready_low", v), rdy_a, 0);
      wait_ready_both(2500, $sformatf("v%0d_applied", v));
      wait_tick(0, 300, $sformatf("v%0d_tick_a", v));
      count_window(0, RES, hr, hg, hb, nft);
      check($sformatf("v%0d_a_r", v), hr, tbl[v].a_r);
      check($sformatf("v%0d_a_g", v), hg, tbl[v].a_g);
      check($sformatf("v%0d_a_b", v), hb, tbl[v].a_b);
      wait_tick(1, 1100, $sformatf("v%0d_tick_b", v));
      count_window(1, 4 * RES, hr, hg, hb, nft);
      check($sformatf("v%0d_b_r", v), hr, tbl[v].b_r);
      check($sformatf("v%0d_b_g", v), hg, tbl[v].b_g);
      check($sformatf("v%0d_b_b", v), hb, tbl[v].b_b);
    end

    // Transfer on the exact wrap edge: old duty (r=2) holds one more full frame.
    for (int k = 0; k < 300 && (m_cnt[0] % RES) != RES - 1; k++) cycle();
    duty_data  = 24'h000030;
    duty_valid = 1'b1;
    cycle();
    duty_valid = 1'b0;
    check("wrapx_tick", ft_a, 1);
    check("wrapx_ready", rdy_a, 0);
    count_window(0, RES, hr, hg, hb, nft);
    check("wrapx_old_r", hr, 2);
    check("wrapx_ready_after", rdy_a, 1);
    count_window(0, RES, hr, hg, hb, nft);
    check("wrapx_new_r", hr, 48);

    // valid held with a second value while pending.
    wait_ready_both(1100, "hold_idle");
    duty_data  = 24'h102030;
    duty_valid = 1'b1;
    cycle();
    check("hold_first_cap", rdy_a, 0);
    duty_data = 24'h405060;
    for (int k = 0; k < 300 && !rdy_a; k++) cycle();
    check("hold_ready_rise", rdy_a, 1);
    cycle();
    duty_valid = 1'b0;
    check("hold_second_cap", rdy_a, 0);
    hr = int'(r_a); hg = int'(g_a); hb = int'(b_a);
    begin
      int r2, g2, b2;
      count_window(0, RES - 1, r2, g2, b2, nft);
      check("hold_first_r", hr + r2, 8'h30);
      check("hold_first_g", hg + g2, 8'h20);
      check("hold_first_b", hb + b2, 8'h10);
    end
    count_window(0, RES, hr, hg, hb, nft);
    check("hold_second_r", hr, 8'h60);
    check("hold_second_g", hg, 8'h50);
    check("hold_second_b", hb, 8'h40);

    // en dropped mid-frame with a pending value.
    wait_ready_both(1100, "endrop_idle");
    wait_tick(0, 300, "endrop_sync");
    duty_data  = 24'h0A0B0C;
    duty_valid = 1'b1;
    cycle();
    duty_valid = 1'b0;
    repeat (100) cycle();
    en = 1'b0;
    cycle();
    check("endrop_out", got(0), 5'b10000);
    repeat (5) cycle();
    check("endrop_idle_out", got(0), 5'b10000);
    en       = 1'b1;
    first_ft = -1;
    hr = 0; hg = 0; hb = 0;
    for (int k = 0; k < RES; k++) begin
      cycle();
      hr += int'(r_a); hg += int'(g_a); hb += int'(b_a);
      if (ft_a && first_ft < 0) first_ft = k;
    end
    check("endrop_first_tick", first_ft, 254);
    check("endrop_r", hr, 12);
    check("endrop_g", hg, 11);
    check("endrop_b", hb, 10);

    // Reset while pending discards the value; no pulse after release.
    duty_data  = 24'hFFFFFF;
    duty_valid = 1'b1;
    cycle();
    duty_valid = 1'b0;
    repeat (7) cycle();
    apply_reset();
    count_window(0, RES, hr, hg, hb, nft);
    check("rstpend_high", hr + hg + hb, 0);
    check("rstpend_ready", rdy_a, 1);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      en         = ($urandom_range(0, 63) != 0);
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_data  = {rnd_duty(), rnd_duty(), rnd_duty()};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
